// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: decode-side, forwarding and ALU-side signals of the operand stage
// master: drives decode fields, forwarding buses, flush, out_ready; observes stage outputs
// slave : the operand stage itself
interface alu_operand_stage_if #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_rd1;
    logic [WIDTH-1:0]   in_rd2;
    logic [REGBITS-1:0] in_rs;
    logic [REGBITS-1:0] in_rt;
    logic [REGBITS-1:0] in_dest;
    logic [15:0]        in_imm;
    logic               in_alusrc;
    logic               in_zext;
    logic [2:0]         in_f;
    logic               in_regwrite;
    logic               in_memtoreg;
    logic               fwd_mem_we;
    logic [REGBITS-1:0] fwd_mem_reg;
    logic [WIDTH-1:0]   fwd_mem_data;
    logic               fwd_wb_we;
    logic [REGBITS-1:0] fwd_wb_reg;
    logic [WIDTH-1:0]   fwd_wb_data;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         f;
    logic [REGBITS-1:0] out_dest;
    logic               out_regwrite;
    logic               out_memtoreg;
    logic [WIDTH-1:0]   out_wdata;
    modport master (
        output in_valid, in_rd1, in_rd2, in_rs, in_rt, in_dest, in_imm, in_alusrc, in_zext,
               in_f, in_regwrite, in_memtoreg, fwd_mem_we, fwd_mem_reg, fwd_mem_data,
               fwd_wb_we, fwd_wb_reg, fwd_wb_data, flush, out_ready,
        input  in_ready, out_valid, a, b, f, out_dest, out_regwrite, out_memtoreg, out_wdata
    );
    modport slave (
        input  in_valid, in_rd1, in_rd2, in_rs, in_rt, in_dest, in_imm, in_alusrc, in_zext,
               in_f, in_regwrite, in_memtoreg, fwd_mem_we, fwd_mem_reg, fwd_mem_data,
               fwd_wb_we, fwd_wb_reg, fwd_wb_data, flush, out_ready,
        output in_ready, out_valid, a, b, f, out_dest, out_regwrite, out_memtoreg, out_wdata
    );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register with MEM/WB forwarding, immediate select and load-use stall
// clk   : rising-edge clock
// reset : asynchronous active-low reset
// bus   : slave side of alu_operand_stage_if (decode handshake, forwarding, ALU handshake)
module alu_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_operand_stage_if.slave   bus
);
    logic               r_valid;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_f;
    logic [REGBITS-1:0] r_dest;
    logic               r_regwrite;
    logic               r_memtoreg;
    logic [WIDTH-1:0]   r_wdata;
    logic [WIDTH-1:0]   w_fwd_a;
    logic [WIDTH-1:0]   w_fwd_b;
    logic [WIDTH-1:0]   w_imm;
    logic               w_hazard;
    logic               w_load_en;
    logic               w_in_ready;
    logic               w_xfer;
    // register 0 is hard-wired, so it is never forwarded; MEM is younger and wins over WB
    always_comb begin
        w_fwd_a = bus.in_rs == '0 ? bus.in_rd1 :
                  bus.fwd_mem_we && bus.fwd_mem_reg == bus.in_rs ? bus.fwd_mem_data :
                  bus.fwd_wb_we && bus.fwd_wb_reg == bus.in_rs ? bus.fwd_wb_data : bus.in_rd1;
        w_fwd_b = bus.in_rt == '0 ? bus.in_rd2 :
                  bus.fwd_mem_we && bus.fwd_mem_reg == bus.in_rt ? bus.fwd_mem_data :
                  bus.fwd_wb_we && bus.fwd_wb_reg == bus.in_rt ? bus.fwd_wb_data : bus.in_rd2;
        w_imm = bus.in_zext ? {{(WIDTH-16){1'b0}}, bus.in_imm} : {{(WIDTH-16){bus.in_imm[15]}}, bus.in_imm};
        // a load sitting here has no data yet; rt only matters when it feeds B
        w_hazard = r_valid && r_memtoreg && r_regwrite && r_dest != '0 &&
                   (r_dest == bus.in_rs || (r_dest == bus.in_rt && !bus.in_alusrc));
        w_load_en = !r_valid || bus.out_ready;
        w_in_ready = w_load_en && !w_hazard && !bus.flush;
        w_xfer = bus.in_valid && w_in_ready;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_f        <= '0;
            r_dest     <= '0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_wdata    <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_valid    <= 1'b1;
            r_a        <= w_fwd_a;
            r_b        <= bus.in_alusrc ? w_imm : w_fwd_b;
            r_f        <= bus.in_f;
            r_dest     <= bus.in_dest;
            r_regwrite <= bus.in_regwrite;
            r_memtoreg <= bus.in_memtoreg;
            r_wdata    <= w_fwd_b;
        end else if (w_load_en) begin
            r_valid <= 1'b0;
        end
    end
    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_valid;
    assign bus.a            = r_a;
    assign bus.b            = r_b;
    assign bus.f            = r_f;
    assign bus.out_dest     = r_dest;
    assign bus.out_regwrite = r_regwrite;
    assign bus.out_memtoreg = r_memtoreg;
    assign bus.out_wdata    = r_wdata;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed self-checking bench for alu_operand_stage
module tb_alu_operand_stage;
    logic clk = 0;
    logic reset = 0;
    int n_checks = 0;
    int n_fail = 0;
    alu_operand_stage_if #(.WIDTH(32), .REGBITS(5)) bus ();
    alu_operand_stage #(.WIDTH(32), .REGBITS(5)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    task automatic idle();
        bus.in_valid = 0; bus.in_rd1 = 0; bus.in_rd2 = 0; bus.in_rs = 0; bus.in_rt = 0;
        bus.in_dest = 0; bus.in_imm = 0; bus.in_alusrc = 0; bus.in_zext = 0; bus.in_f = 0;
        bus.in_regwrite = 0; bus.in_memtoreg = 0; bus.fwd_mem_we = 0; bus.fwd_mem_reg = 0;
        bus.fwd_mem_data = 0; bus.fwd_wb_we = 0; bus.fwd_wb_reg = 0; bus.fwd_wb_data = 0;
        bus.flush = 0; bus.out_ready = 1;
    endtask
    task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic [15:0] imm,
                       input logic alusrc, input logic zext, input logic [2:0] fn,
                       input logic memtoreg);
        bus.in_valid = 1; bus.in_rs = rs; bus.in_rt = rt; bus.in_dest = dest;
        bus.in_rd1 = rd1; bus.in_rd2 = rd2; bus.in_imm = imm; bus.in_alusrc = alusrc;
        bus.in_zext = zext; bus.in_f = fn; bus.in_regwrite = 1; bus.in_memtoreg = memtoreg;
    endtask
    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic test_reset();
        idle();
        #12;
        chk("rst out_valid", {31'b0, bus.out_valid}, 0);
        chk("rst a", bus.a, 0);
        chk("rst b", bus.b, 0);
        chk("rst f", {29'b0, bus.f}, 0);
        chk("rst out_dest", {27'b0, bus.out_dest}, 0);
        chk("rst out_regwrite", {31'b0, bus.out_regwrite}, 0);
        chk("rst out_memtoreg", {31'b0, bus.out_memtoreg}, 0);
        @(negedge clk); reset = 1;
    endtask
    task automatic test_add();
        @(negedge clk);
        drv(1, 2, 3, 5, 7, 0, 0, 0, 3'b010, 0);
        step();
        chk("add out_valid", {31'b0, bus.out_valid}, 1);
        chk("add a", bus.a, 5);
        chk("add b", bus.b, 7);
        chk("add f", {29'b0, bus.f}, 2);
        chk("add dest", {27'b0, bus.out_dest}, 3);
        chk("add wdata", bus.out_wdata, 7);
        chk("add regwrite", {31'b0, bus.out_regwrite}, 1);
        @(negedge clk); idle();
        step();
        chk("add drained", {31'b0, bus.out_valid}, 0);
    endtask
    task automatic test_imm();
        @(negedge clk);
        drv(1, 4, 4, 9, 32'h1234, 16'h8001, 1, 1, 3'b001, 0);
        step();
        chk("ori b", bus.b, 32'h00008001);
        chk("ori wdata", bus.out_wdata, 32'h1234);
        @(negedge clk);
        drv(1, 4, 4, 9, 32'h1234, 16'h8001, 1, 0, 3'b010, 0);
        step();
        chk("addi b", bus.b, 32'hFFFF8001);
        chk("addi valid", {31'b0, bus.out_valid}, 1);
        @(negedge clk); idle();
    endtask
    task automatic test_forward();
        @(negedge clk);
        drv(3, 2, 6, 32'h11, 32'h22, 0, 0, 0, 3'b010, 0);
        bus.fwd_mem_we = 1; bus.fwd_mem_reg = 3; bus.fwd_mem_data = 32'hAA;
        bus.fwd_wb_we = 1; bus.fwd_wb_reg = 3; bus.fwd_wb_data = 32'hBB;
        step();
        chk("fwd mem prio a", bus.a, 32'hAA);
        chk("fwd no match b", bus.b, 32'h22);
        @(negedge clk); bus.fwd_mem_we = 0;
        step();
        chk("fwd wb a", bus.a, 32'hBB);
        @(negedge clk);
        bus.in_rs = 0; bus.in_rd1 = 32'h55;
        bus.fwd_mem_we = 1; bus.fwd_mem_reg = 0; bus.fwd_wb_reg = 0;
        step();
        chk("fwd reg0 a", bus.a, 32'h55);
        @(negedge clk);
        bus.in_rs = 1; bus.in_rt = 7; bus.fwd_mem_reg = 7; bus.fwd_mem_data = 32'hC7;
        step();
        chk("fwd rt b", bus.b, 32'hC7);
        chk("fwd rt wdata", bus.out_wdata, 32'hC7);
        @(negedge clk); idle();
        step();
    endtask
    task automatic test_load_use();
        @(negedge clk);
        drv(1, 8, 8, 100, 0, 4, 1, 0, 3'b010, 1);
        step();
        chk("lw valid", {31'b0, bus.out_valid}, 1);
        chk("lw memtoreg", {31'b0, bus.out_memtoreg}, 1);
        @(negedge clk);
        drv(8, 2, 9, 32'h0BAD, 32'h3, 0, 0, 0, 3'b010, 0);
        #1;
        chk("lu in_ready stalled", {31'b0, bus.in_ready}, 0);
        step();
        chk("lu bubble", {31'b0, bus.out_valid}, 0);
        chk("lu in_ready resumed", {31'b0, bus.in_ready}, 1);
        @(negedge clk);
        bus.fwd_mem_we = 1; bus.fwd_mem_reg = 8; bus.fwd_mem_data = 32'hDEAD;
        step();
        chk("lu add valid", {31'b0, bus.out_valid}, 1);
        chk("lu add a", bus.a, 32'hDEAD);
        chk("lu add b", bus.b, 32'h3);
        @(negedge clk); idle();
        step();
    endtask
    task automatic test_back_to_back();
        @(negedge clk);
        drv(1, 2, 5, 32'h11, 0, 0, 0, 0, 3'b000, 0);
        step();
        chk("b2b first", bus.a, 32'h11);
        @(negedge clk);
        bus.out_ready = 0; bus.in_rd1 = 32'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall in_ready", {31'b0, bus.in_ready}, 0);
            step();
            chk("stall a held", bus.a, 32'h11);
            chk("stall valid held", {31'b0, bus.out_valid}, 1);
            @(negedge clk);
        end
        bus.out_ready = 1;
        #1;
        chk("release in_ready", {31'b0, bus.in_ready}, 1);
        step();
        chk("b2b second", bus.a, 32'h22);
        @(negedge clk); bus.in_rd1 = 32'h33;
        step();
        chk("b2b third", bus.a, 32'h33);
        chk("b2b third valid", {31'b0, bus.out_valid}, 1);
        @(negedge clk); idle();
        step();
        chk("b2b no dup", {31'b0, bus.out_valid}, 0);
    endtask
    task automatic test_flush();
        @(negedge clk);
        drv(1, 2, 5, 32'h44, 0, 0, 0, 0, 3'b000, 0);
        step();
        chk("flush pre a", bus.a, 32'h44);
        @(negedge clk);
        bus.in_rd1 = 32'h55; bus.flush = 1;
        #1;
        chk("flush in_ready", {31'b0, bus.in_ready}, 0);
        step();
        chk("flush valid", {31'b0, bus.out_valid}, 0);
        chk("flush no capture", bus.a, 32'h44);
        @(negedge clk); idle();
    endtask
    task automatic test_reset_mid();
        @(negedge clk);
        drv(1, 2, 7, 32'h66, 32'h77, 0, 0, 0, 3'b011, 1);
        step();
        chk("mid pre valid", {31'b0, bus.out_valid}, 1);
        #2 reset = 0;
        #1;
        chk("mid rst valid", {31'b0, bus.out_valid}, 0);
        chk("mid rst a", bus.a, 0);
        chk("mid rst b", bus.b, 0);
        chk("mid rst f", {29'b0, bus.f}, 0);
        chk("mid rst dest", {27'b0, bus.out_dest}, 0);
        chk("mid rst memtoreg", {31'b0, bus.out_memtoreg}, 0);
        @(negedge clk); idle(); reset = 1;
        step();
        chk("mid post valid", {31'b0, bus.out_valid}, 0);
    endtask
    initial begin
        test_reset();
        test_add();
        test_imm();
        test_forward();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU: it captures decoded operands from decode/register-file read and resolves forwarding from the MEM and WB stages.
- Selects register or immediate for the B operand and presents registered a, b and f to the ALU.
- Detects load-use hazards and stalls decode for them.
- Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, datapath width.
- REGBITS, 5, register index width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  stage accepts this cycle
- in_rd1  input  WIDTH  register-file value of rs
- in_rd2  input  WIDTH  register-file value of rt
- in_rs  input  REGBITS  rs index
- in_rt  input  REGBITS  rt index
- in_dest  input  REGBITS  destination index
- in_imm  input  16  instruction immediate
- in_alusrc  input  1  1 = B operand is immediate
- in_zext  input  1  1 = zero-extend immediate (andi/ori), 0 = sign-extend
- in_f  input  3  ALU function code
- in_regwrite  input  1  instruction writes a register
- in_memtoreg  input  1  instruction is a load
- fwd_mem_we  input  1  MEM stage writes a register
- fwd_mem_reg  input  REGBITS  MEM destination
- fwd_mem_data  input  WIDTH  MEM result
- fwd_wb_we  input  1  WB stage writes a register
- fwd_wb_reg  input  REGBITS  WB destination
- fwd_wb_data  input  WIDTH  WB result
- flush  input  1  squash stage contents (taken branch)
- out_valid  output  1  a/b/f valid for ALU
- out_ready  input  1  EX consumes this cycle
- a  output  WIDTH  ALU operand A
- b  output  WIDTH  ALU operand B
- f  output  3  ALU function
- out_dest  output  REGBITS  registered destination
- out_regwrite  output  1  registered write-enable
- out_memtoreg  output  1  registered load flag
- out_wdata  output  WIDTH  forwarded rt value (store data)

Behaviour:
- Reset (asynchronous, reset low): all outputs are 0, including out_valid, a, b, f = 3'b000, out_dest, out_regwrite and out_memtoreg.
- Forwarding is combinational on in_* and applies to each of rs and rt independently:
  - Index 0 always yields in_rdX; it is never forwarded.
  - Otherwise, if fwd_mem_we && fwd_mem_reg matches, use fwd_mem_data.
  - Else, if fwd_wb_we && fwd_wb_reg matches, use fwd_wb_data.
  - Else use in_rdX.
  - MEM has priority over WB.
- Immediate extension:
  - in_zext = 1: {16'b0, in_imm}.
  - in_zext = 0: sign-extended to WIDTH.
- B operand: the extended immediate if in_alusrc, else forwarded rt. out_wdata is always the forwarded rt.
- Hazard: asserted when out_valid && out_memtoreg && out_regwrite && out_dest != 0, and either:
  - out_dest == in_rs, or
  - out_dest == in_rt && !in_alusrc.
- Handshake:
  - load_en = !out_valid || out_ready.
  - in_ready = load_en && !hazard. It is combinational and may depend on out_ready.
  - Transfer occurs when in_valid && in_ready.
- Register update per cycle, highest priority first:
  1. flush → out_valid <= 0. in_ready is forced 0 that cycle and no capture occurs.
  2. Transfer → capture all outputs; out_valid <= 1.
  3. load_en without transfer (including a hazard with the load consumed) → out_valid <= 0, inserting a bubble.
  4. Otherwise hold all outputs unchanged.
- Latency: one cycle from transfer to out_valid.
- Throughput: one instruction per cycle with out_ready held high.
- Load-use costs exactly one bubble. The load leaves EX, the dependent instruction is accepted the next cycle, and its value is forwarded from MEM.
- Data outputs are don't-care while out_valid = 0 but must not change unless a capture occurs.
- Reset asserted mid-stream clears out_valid immediately. Any in-flight instruction is lost.

Test Plan:
- add, rd1 = 5, rd2 = 7, f = 010, no forwarding → one cycle later out_valid = 1, a = 5, b = 7, f = 010.
- ori with imm = 16'h8001, in_zext = 1 → b = 32'h00008001. Same imm with in_zext = 0 (addi) → b = 32'hFFFF8001.
- rs = 3 with fwd_mem (reg 3, data 0xAA) and fwd_wb (reg 3, data 0xBB) both asserted → a = 0xAA. Drop fwd_mem → a = 0xBB. rs = 0 with forwards on reg 0 → a = in_rd1.
- lw into $8 held in stage, next instruction add rs = 8 → in_ready = 0 for one cycle and out_valid = 0 the following cycle. The add is accepted next, with a taken from fwd_mem_data.
- out_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0 and outputs stable. Release → back-to-back transfers, no loss or duplication.
- flush with out_valid = 1 and in_valid = 1 → out_valid = 0 next cycle, nothing captured. Reset pulse mid-stream → all outputs 0 asynchronously.
